// File: rtl/mem_byte_loader.sv
// mem_byte_loader
//   Turns a byte stream of header/data bytes into 16-bit word writes to, and
//   word reads from, an 8-entry x 16-bit memory. Read words come back as two
//   bytes, low byte first.
//
//   Header byte: bit7 = 1 write / 0 read, bits[2:0] = start word address.
//   Write command: header, low data byte, high data byte, then one write cycle.
//   Read command:  header, one wait cycle, then the low byte and the high byte.
//
//   Optional feature, enabled by defining BURST_AUTOINC_EN:
//     header bit6 = 1 selects a burst of (bits[5:3] + 1) words. The address
//     increments modulo 8 after every word. Without the macro, bits[6:3] are
//     ignored and every command moves exactly one word.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream byte available
//   in_byte    in   upstream header/data byte
//   in_ready   out  loader can take a byte (IDLE, GET_LO, GET_HI)
//   mem_addr   out  word address to memory
//   mem_wdata  out  write data to memory
//   mem_we     out  write strobe, high for the single WRITE cycle
//   mem_rdata  in   memory read data
//   out_valid  out  read byte available downstream
//   out_byte   out  read byte (0 when out_valid is low)
//   out_ready  in   downstream accepts the byte
module mem_byte_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic [2:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  input  logic        out_ready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_LO  = 3'd1,
    GET_HI  = 3'd2,
    WRITE   = 3'd3,
    RD_WAIT = 3'd4,
    SEND_LO = 3'd5,
    SEND_HI = 3'd6
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] rdata_q;
  logic        in_acc;
  logic        out_acc;
  logic        more;

  assign in_acc  = in_valid & in_ready;
  assign out_acc = out_valid & out_ready;

`ifdef BURST_AUTOINC_EN
  logic       burst_q;
  logic [2:0] cnt_q;

  // cnt_q holds the number of words still to move after the current one.
  assign more = burst_q & (cnt_q != 3'd0);
`else
  logic unused_hdr_bits;

  assign more            = 1'b0;
  assign unused_hdr_bits = ^in_byte[6:3];
`endif

  // Decoded outputs: all follow the state register directly, so reset forces
  // them at once without waiting for a clock edge.
  assign in_ready  = (state_q == IDLE) | (state_q == GET_LO) | (state_q == GET_HI);
  assign mem_we    = (state_q == WRITE);
  assign out_valid = (state_q == SEND_LO) | (state_q == SEND_HI);

  always_comb begin
    out_byte = 8'h00;
    if (state_q == SEND_LO) out_byte = rdata_q[7:0];
    else if (state_q == SEND_HI) out_byte = rdata_q[15:8];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_acc) state_d = in_byte[7] ? GET_LO : RD_WAIT;
      GET_LO:  if (in_acc) state_d = GET_HI;
      GET_HI:  if (in_acc) state_d = WRITE;
      WRITE:   state_d = more ? GET_LO : IDLE;
      RD_WAIT: state_d = SEND_LO;
      SEND_LO: if (out_acc) state_d = SEND_HI;
      SEND_HI: if (out_acc) state_d = more ? RD_WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and the memory-facing registers. Reset discards any partial
  // command, so a half-received write can never reach the memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mem_addr  <= 3'd0;
      mem_wdata <= 16'h0000;
`ifdef BURST_AUTOINC_EN
      burst_q   <= 1'b0;
      cnt_q     <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_acc) begin
          mem_addr <= in_byte[2:0];
`ifdef BURST_AUTOINC_EN
          burst_q  <= in_byte[6];
          cnt_q    <= in_byte[6] ? in_byte[5:3] : 3'd0;
`endif
        end
        GET_LO: if (in_acc) mem_wdata[7:0]  <= in_byte;
        GET_HI: if (in_acc) mem_wdata[15:8] <= in_byte;
        default: ;
      endcase
`ifdef BURST_AUTOINC_EN
      // Advance to the next word of a burst; 3-bit add wraps 7 to 0.
      if (more && ((state_q == WRITE) || ((state_q == SEND_HI) && out_acc))) begin
        mem_addr <= mem_addr + 3'd1;
        cnt_q    <= cnt_q - 3'd1;
      end
`endif
    end
  end

  // Read data capture at the end of the single RD_WAIT cycle; only ever
  // observed in SEND_LO/SEND_HI, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state_q == RD_WAIT) rdata_q <= mem_rdata;
  end

endmodule

// File: tb/tb_mem_byte_loader.sv
module tb_mem_byte_loader;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic [2:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic        out_valid;
  logic [7:0]  out_byte;
  logic        out_ready;

  int n_checks = 0;
  int n_errors = 0;

  mem_byte_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_byte  (out_byte),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    mem_rdata = 16'h0000;
    out_ready = 1'b0;
    rst_n     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  {15'd0, in_ready},  16'd1);
    chk("rst_mem_we",    {15'd0, mem_we},    16'd0);
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_out_byte",  {8'd0, out_byte},   16'd0);
    chk("rst_mem_addr",  {13'd0, mem_addr},  16'd0);
    chk("rst_mem_wdata", mem_wdata,          16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {15'd0, in_ready}, 16'd1);

    // Write 0x87, 0x53, 0x12 with an input stall inside GET_LO
    in_valid = 1'b1; in_byte = 8'h87;
    @(negedge clk);
    chk("getlo_addr", {13'd0, mem_addr}, 16'd7);
    chk("getlo_we",   {15'd0, mem_we},   16'd0);
    in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("stall_in_ready", {15'd0, in_ready}, 16'd1);
      chk("stall_we",       {15'd0, mem_we},   16'd0);
      chk("stall_wdata",    mem_wdata,         16'h0000);
    end
    in_valid = 1'b1; in_byte = 8'h53;
    @(negedge clk);
    chk("gethi_wdata_lo", {8'd0, mem_wdata[7:0]}, 16'h0053);
    chk("gethi_we",       {15'd0, mem_we},        16'd0);
    in_byte = 8'h12;
    @(negedge clk);
    in_valid = 1'b0;
    chk("write_we",       {15'd0, mem_we},   16'd1);
    chk("write_addr",     {13'd0, mem_addr}, 16'd7);
    chk("write_wdata",    mem_wdata,         16'h1253);
    chk("write_in_ready", {15'd0, in_ready}, 16'd0);
    @(negedge clk);
    chk("postwr_we",       {15'd0, mem_we},   16'd0);
    chk("postwr_in_ready", {15'd0, in_ready}, 16'd1);
    chk("postwr_addr",     {13'd0, mem_addr}, 16'd7);

    // Read 0x07 with backpressure in SEND_LO
    in_valid = 1'b1; in_byte = 8'h07; mem_rdata = 16'h1253; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rdwait_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rdwait_out_byte",  {8'd0, out_byte},   16'd0);
    chk("rdwait_in_ready",  {15'd0, in_ready},  16'd0);
    @(negedge clk);
    mem_rdata = 16'hFFFF;
    chk("sendlo_valid", {15'd0, out_valid}, 16'd1);
    chk("sendlo_byte",  {8'd0, out_byte},   16'h0053);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_byte",     {8'd0, out_byte},   16'h0053);
      chk("bp_valid",    {15'd0, out_valid}, 16'd1);
      chk("bp_in_ready", {15'd0, in_ready},  16'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("sendhi_byte",  {8'd0, out_byte},   16'h0012);
    chk("sendhi_valid", {15'd0, out_valid}, 16'd1);
    @(negedge clk);
    out_ready = 1'b0;
    chk("rdidle_valid",    {15'd0, out_valid}, 16'd0);
    chk("rdidle_byte",     {8'd0, out_byte},   16'd0);
    chk("rdidle_in_ready", {15'd0, in_ready},  16'd1);

    // Reset in the middle of a write, then a read of address 2
    in_valid = 1'b1; in_byte = 8'h87;
    @(negedge clk);
    in_byte = 8'h53;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_in_ready", {15'd0, in_ready}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_we",       {15'd0, mem_we},   16'd0);
    chk("async_rst_addr",     {13'd0, mem_addr}, 16'd0);
    chk("async_rst_wdata",    mem_wdata,         16'h0000);
    chk("async_rst_in_ready", {15'd0, in_ready}, 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("postrst_no_we", {15'd0, mem_we}, 16'd0);
    end
    in_valid = 1'b1; in_byte = 8'h02; mem_rdata = 16'hABCD; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_rd_addr", {13'd0, mem_addr}, 16'd2);
    chk("rst_rd_we",   {15'd0, mem_we},   16'd0);
    @(negedge clk);
    chk("rst_rd_lo", {8'd0, out_byte}, 16'h00CD);
    @(negedge clk);
    chk("rst_rd_hi", {8'd0, out_byte}, 16'h00AB);
    @(negedge clk);
    out_ready = 1'b0;
    chk("rst_rd_idle", {15'd0, out_valid}, 16'd0);

`ifdef BURST_AUTOINC_EN
    // Burst write of four words starting at address 6
    begin
      logic [2:0] exp_addr [4];
      int         pulses;
      exp_addr[0] = 3'd6; exp_addr[1] = 3'd7; exp_addr[2] = 3'd0; exp_addr[3] = 3'd1;
      pulses = 0;
      in_valid = 1'b1; in_byte = 8'hDE;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (mem_we) begin
          if (pulses < 4) chk("burst_addr", {13'd0, mem_addr}, {13'd0, exp_addr[pulses]});
          pulses++;
        end
        in_byte = 8'h10 + 8'(i);
      end
      in_valid = 1'b0;
      chk("burst_pulses", 16'(pulses), 16'd4);
    end
`else
    // Burst bits ignored: 0xDE is a single write to address 6
    in_valid = 1'b1; in_byte = 8'hDE;
    @(negedge clk);
    in_byte = 8'h11;
    @(negedge clk);
    in_byte = 8'h22;
    @(negedge clk);
    in_valid = 1'b0;
    chk("nb_we",    {15'd0, mem_we},   16'd1);
    chk("nb_addr",  {13'd0, mem_addr}, 16'd6);
    chk("nb_wdata", mem_wdata,         16'h2211);
    @(negedge clk);
    chk("nb_idle_we",       {15'd0, mem_we},   16'd0);
    chk("nb_idle_in_ready", {15'd0, in_ready}, 16'd1);
    repeat (3) begin
      @(negedge clk);
      chk("nb_no_more_we", {15'd0, mem_we}, 16'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_byte_loader.md
MEM_BYTE_LOADER -- requirements
Module: mem_byte_loader

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: in_valid  input  1  upstream byte available.
REQ-004 SHALL have port: in_byte  input  8  upstream command/data byte.
REQ-005 SHALL have port: in_ready  output  1  byte accepted when in_valid and in_ready are both high at a rising edge.
REQ-006 SHALL have port: mem_addr  output  3  word address to the 8x16 DFF memory.
REQ-007 SHALL have port: mem_wdata  output  16  write data to memory.
REQ-008 SHALL have port: mem_we  output  1  memory write strobe, active high.
REQ-009 SHALL have port: mem_rdata  input  16  memory read data, valid from the cycle after mem_addr is stable.
REQ-010 SHALL have port: out_valid  output  1  read byte available downstream.
REQ-011 SHALL have port: out_byte  output  8  read data byte.
REQ-012 SHALL have port: out_ready  input  1  downstream accepts when out_valid and out_ready are both high at a rising edge.

Function
REQ-013 SHALL parse a header byte: bit7 = 1 write / 0 read; bits[2:0] = start address; bits[6:3] ignored unless REQ-030 applies.
REQ-014 SHALL implement states IDLE, GET_LO, GET_HI, WRITE, RD_WAIT, SEND_LO, SEND_HI.
REQ-015 SHALL assert in_ready only in IDLE, GET_LO and GET_HI.
REQ-016 IDLE: on header accept, SHALL load mem_addr; write -> GET_LO, read -> RD_WAIT.
REQ-017 GET_LO: on accept SHALL store byte in mem_wdata[7:0] -> GET_HI; GET_HI: store in mem_wdata[15:8] -> WRITE.
REQ-018 WRITE SHALL last exactly one cycle with mem_we=1; mem_addr and mem_wdata stable throughout; next state IDLE.
REQ-019 mem_we SHALL be 0 in every state other than WRITE.
REQ-020 RD_WAIT SHALL last exactly one cycle, then capture mem_rdata into an internal 16-bit register -> SEND_LO.
REQ-021 SEND_LO SHALL drive out_valid=1, out_byte=captured[7:0]; on handshake -> SEND_HI.
REQ-022 SEND_HI SHALL drive out_valid=1, out_byte=captured[15:8]; on handshake -> IDLE.
REQ-023 While out_valid=1 and out_ready=0, out_byte SHALL hold unchanged.
REQ-024 out_valid SHALL be 0 outside SEND_LO/SEND_HI; out_byte SHALL be 0 when out_valid=0.
REQ-025 in_valid=0 in a receive state SHALL stall with no state or register change.
REQ-026 Header-to-mem_we latency: 3 cycles minimum when data bytes arrive back-to-back.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, mem_addr=0, mem_wdata=0, mem_we=0, out_valid=0, out_byte=0, in_ready=1 after release.
REQ-028 Reset mid-command SHALL discard the partial command; no memory write SHALL occur for it.
REQ-029 First accepted byte after reset release SHALL be treated as a header.

Configuration
REQ-030 With BURST_AUTOINC_EN defined: header bit6=1 SHALL enable burst, bits[5:3] = word count minus 1 (1..8 words); after each WRITE or SEND_HI, mem_addr SHALL increment modulo 8 (7 wraps to 0) and the FSM SHALL return to GET_LO (write) or RD_WAIT (read) until the count is exhausted, then IDLE.
REQ-031 Without BURST_AUTOINC_EN: bits[6:3] SHALL be ignored; every command SHALL be one word; no count register SHALL exist.

Verification
REQ-032 Write: bytes 0x87, 0x53, 0x12 -> one cycle mem_we=1, mem_addr=7, mem_wdata=0x1253.
REQ-033 Read: byte 0x07, mem_rdata=0x1253 -> out_byte 0x53 then 0x12, each with out_valid=1; then IDLE.
REQ-034 Backpressure: out_ready=0 for 5 cycles in SEND_LO -> out_byte holds 0x53, out_valid stays 1, in_ready=0.
REQ-035 Reset after 0x87, 0x53 accepted -> no mem_we pulse; next bytes 0x02 then mem_rdata=0xABCD -> outputs 0xCD, 0xAB.
REQ-036 BURST_AUTOINC_EN: header 0xDE plus 8 data bytes -> four mem_we pulses at addresses 6, 7, 0, 1.
REQ-037 Without macro: header 0xDE, 0x11, 0x22 -> single write of 0x2211 to address 6; FSM returns to IDLE.
